trap_sequencer: RTL

//  Machine-mode trap and interrupt sequencer alongside the CSR/exception unit in the XB stage.

---
 rtl/trap_seq_if.sv | 37 +++
 rtl/trap_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/trap_seq_if.sv
// Bus between the XB-stage pipeline/CSR unit and the machine-mode trap sequencer.
// No valid/ready pairs: requests are level/strobe inputs sampled on every rising edge, and
// flush/redirect/irq_take are single-cycle strobes the pipeline must act on in that cycle.
interface trap_seq_if;
  logic        XB_bubble;
  logic        exc_req;
  logic        mret;
  logic        irq_ext;
  logic        irq_soft;
  logic        irq_timer;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        flush;
  logic        redirect;
  logic        redirect_sel;
  logic        irq_take;
  logic [31:0] irq_cause;
  logic        pipeline_hold;
  logic [1:0]  state_dbg;

  modport master (
    output XB_bubble, exc_req, mret, irq_ext, irq_soft, irq_timer,
           csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit, flush, redirect, redirect_sel,
           irq_take, irq_cause, pipeline_hold, state_dbg
  );

  modport slave (
    input  XB_bubble, exc_req, mret, irq_ext, irq_soft, irq_timer,
           csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_hit, flush, redirect, redirect_sel,
           irq_take, irq_cause, pipeline_hold, state_dbg
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/interrupt sequencer: owns mstatus.MIE/MPIE, mie, mip and drives the
// flush -> redirect -> drain sequence for exceptions, MRET and level interrupts.
module trap_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter bit          IRQ_SYNC     = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  trap_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRAP  = 2'd1;
  localparam logic [1:0] RET   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [3:0]  DRAIN_LOAD   = 4'(DRAIN_CYCLES - 1);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic [1:0]  state;
  logic [3:0]  drain_cnt;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_ext, mie_timer, mie_soft;
  logic        trap_is_irq;
  logic [31:0] irq_cause_q;
  logic [31:0] csr_rdata_q;

  // Interrupt levels ordered {ext, timer, soft}, matching mip bits {11, 7, 3}.
  logic [2:0] irq_raw;
  logic [2:0] irq_lvl;
  assign irq_raw = {bus.irq_ext, bus.irq_timer, bus.irq_soft};

  generate
    if (IRQ_SYNC) begin : g_sync
      logic [2:0] sync1, sync2;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1 <= 3'b0;
          sync2 <= 3'b0;
        end else begin
          sync1 <= irq_raw;
          sync2 <= sync1;
        end
      end
      assign irq_lvl = sync2;
    end else begin : g_nosync
      assign irq_lvl = irq_raw;
    end
  endgenerate

  logic [2:0] pend;
  logic       irq_eligible;
  logic [3:0] irq_code;
  assign pend         = irq_lvl & {mie_ext, mie_timer, mie_soft} & {3{mstatus_mie}};
  assign irq_eligible = (|pend) && !bus.XB_bubble;

  always_comb begin
    irq_code = 4'd7;
    if (pend[2])      irq_code = 4'd11;
    else if (pend[0]) irq_code = 4'd3;
  end

  logic [31:0] mstatus_rd, mie_rd, mip_rd, rd_mux;
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_rd     = {20'b0, mie_ext, 3'b0, mie_timer, 3'b0, mie_soft, 3'b0};
  assign mip_rd     = {20'b0, irq_lvl[2], 3'b0, irq_lvl[1], 3'b0, irq_lvl[0], 3'b0};

  always_comb begin
    rd_mux = 32'b0;
    case (bus.csr_addr)
      ADDR_MSTATUS: rd_mux = mstatus_rd;
      ADDR_MIE:     rd_mux = mie_rd;
      ADDR_MIP:     rd_mux = mip_rd;
      default:      rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      drain_cnt    <= 4'd0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_ext      <= 1'b0;
      mie_timer    <= 1'b0;
      mie_soft     <= 1'b0;
      trap_is_irq  <= 1'b0;
      irq_cause_q  <= 32'b0;
      csr_rdata_q  <= 32'b0;
    end else begin
      csr_rdata_q <= rd_mux;
      if (bus.csr_we && bus.csr_addr == ADDR_MIE) begin
        mie_ext   <= bus.csr_wdata[11];
        mie_timer <= bus.csr_wdata[7];
        mie_soft  <= bus.csr_wdata[3];
      end
      // TRAP/RET assignments below come later and therefore win over a same-cycle write.
      if (bus.csr_we && bus.csr_addr == ADDR_MSTATUS) begin
        mstatus_mie  <= bus.csr_wdata[3];
        mstatus_mpie <= bus.csr_wdata[7];
      end
      case (state)
        IDLE: begin
          if (bus.exc_req) begin
            state       <= TRAP;
            trap_is_irq <= 1'b0;
          end else if (bus.mret) begin
            state <= RET;
          end else if (irq_eligible) begin
            state       <= TRAP;
            trap_is_irq <= 1'b1;
            irq_cause_q <= {1'b1, 27'b0, irq_code};
          end
        end
        TRAP: begin
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
          drain_cnt    <= DRAIN_LOAD;
          state        <= DRAIN;
        end
        RET: begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
          drain_cnt    <= DRAIN_LOAD;
          state        <= DRAIN;
        end
        default: begin
          if (drain_cnt == 4'd0) state <= IDLE;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
      endcase
    end
  end

  assign bus.csr_hit       = (bus.csr_addr == ADDR_MSTATUS) || (bus.csr_addr == ADDR_MIE) ||
                             (bus.csr_addr == ADDR_MIP);
  assign bus.csr_rdata     = csr_rdata_q;
  assign bus.flush         = (state == TRAP) || (state == RET);
  assign bus.redirect      = (state == TRAP) || (state == RET);
  assign bus.redirect_sel  = (state == RET);
  assign bus.irq_take      = (state == TRAP) && trap_is_irq;
  assign bus.irq_cause     = irq_cause_q;
  assign bus.pipeline_hold = (state == DRAIN);
  assign bus.state_dbg     = state;

endmodule
